// File: rtl/mem_dump_streamer.sv
// Walks NUM_WORDS data-memory words from BASE_ADDR after the core halts and
// streams each one out as an address/data beat on a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for halt_f
// REQ    | issue one synchronous read for the current word
// WAIT   | read data arrives; latch it into the output beat
// HOLD   | beat presented, waiting for the logger handshake
// DONE   | dump finished, waiting for halt_f to drop before re-arming
module mem_dump_streamer #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  logic [2:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;

  logic [ADDR_W-1:0] cnt_ext;
  logic [ADDR_W-1:0] req_addr;
  logic              handshake;

  // Address wraps silently past the top of the address space.
  assign cnt_ext   = ADDR_W'(cnt_q);
  assign req_addr  = BASE_ADDR + (cnt_ext << 2);
  assign handshake = out_valid_q & out_ready & clk_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (halt_f) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
        end
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          out_data_d  = mem_rd_data;
          out_addr_d  = req_addr;
          out_last_d  = (cnt_q == LAST_CNT);
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          if (handshake) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = S_REQ;
            end
          end
        end
        S_DONE: begin
          out_valid_d = 1'b0;
          if (!halt_f) state_d = S_IDLE;
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Gating the strobe with clk_en keeps a frozen REQ from issuing a read.
  assign mem_rd_en   = clk_en & (state_q == S_REQ);
  assign mem_rd_addr = (state_q == S_REQ) ? req_addr : '0;

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_REQ) | (state_q == S_WAIT) | (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);

endmodule
